// File: rtl/nax_clint_pkg.sv
// Shared constants, bus FSM state type and address helpers for the multi-hart CLINT.
package nax_clint_pkg;

    localparam int unsigned MSIP_BASE     = 32'h0000_0000;
    localparam int unsigned MTIMECMP_BASE = 32'h0000_1000;
    localparam int unsigned MTIME_LO      = 32'h0000_2FFE;
    localparam int unsigned MTIME_HI      = 32'h0000_2FFF;

    localparam logic [63:0] MTIMECMP_RST = '1;

    typedef enum logic {
        BUS_IDLE,
        BUS_ACK
    } bus_state_e;

    // Word address of one 32-bit half of mtimecmp[hart].
    function automatic int unsigned mtimecmp_addr(input int unsigned hart, input logic hi);
        return MTIMECMP_BASE + 2 * hart + (hi ? 32'd1 : 32'd0);
    endfunction

endpackage

// File: rtl/nax_clint_wb_if.sv
// 32-bit Wishbone classic bus carrying CLINT register accesses.
interface nax_clint_wb_if #(
    parameter int unsigned ADR_WIDTH = 14
);
    logic                 CYC;
    logic                 STB;
    logic                 WE;
    logic [ADR_WIDTH-1:0] ADR;
    logic [31:0]          DAT_MOSI;
    logic [31:0]          DAT_MISO;
    logic                 ACK;

    modport master (
        output CYC, STB, WE, ADR, DAT_MOSI,
        input  DAT_MISO, ACK
    );

    modport slave (
        input  CYC, STB, WE, ADR, DAT_MOSI,
        output DAT_MISO, ACK
    );

endinterface

// File: rtl/nax_clint_timer.sv
// Prescaled 64-bit mtime counter with debug freeze and independent 32-bit half writes.
module nax_clint_timer #(
    parameter int unsigned TICK_DIV_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [TICK_DIV_WIDTH-1:0] tick_div_i,
    input  logic                      stop_time_i,
    input  logic                      wr_lo_i,
    input  logic                      wr_hi_i,
    input  logic [31:0]               wdata_i,
    output logic [63:0]               mtime_o
);

    logic [TICK_DIV_WIDTH-1:0] pre_q, pre_d;
    logic [63:0]               mtime_q, mtime_d;
    logic                      tick;

    always_comb begin
        tick  = !stop_time_i && (pre_q >= tick_div_i);
        pre_d = pre_q;
        if (!stop_time_i) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
        end

        // A bus write replaces the tick outright: the untouched half keeps its
        // pre-increment value and the lost tick's carry is discarded.
        mtime_d = mtime_q;
        if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
        if (wr_lo_i) begin
            mtime_d = {mtime_q[63:32], wdata_i};
        end else if (wr_hi_i) begin
            mtime_d = {wdata_i, mtime_q[31:0]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_q   <= '0;
            mtime_q <= '0;
        end else begin
            pre_q   <= pre_d;
            mtime_q <= mtime_d;
        end
    end

    assign mtime_o = mtime_q;

endmodule

// File: rtl/nax_clint_wb.sv
// Multi-hart CLINT: Wishbone slave FSM, address decode, msip/mtimecmp arrays and MTIP compare.
module nax_clint_wb
    import nax_clint_pkg::*;
#(
    parameter int unsigned HART_COUNT     = 1,
    parameter int unsigned ADR_WIDTH      = 14,
    parameter int unsigned TICK_DIV_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    nax_clint_wb_if.slave             wb,
    input  logic [TICK_DIV_WIDTH-1:0] tick_div,
    input  logic                      stop_time,
    output logic [63:0]               mtime,
    output logic [HART_COUNT-1:0]     timer_interrupt,
    output logic [HART_COUNT-1:0]     software_interrupt
);

    bus_state_e                 state_q, state_d;
    logic                       we_q, we_d;
    logic [ADR_WIDTH-1:0]       adr_q, adr_d;
    logic [31:0]                wdat_q, wdat_d;
    logic [31:0]                rdata_q, rdata_d;
    logic [HART_COUNT-1:0]      msip_q, msip_d;
    logic [HART_COUNT-1:0]      mtip_q, mtip_d;
    logic [HART_COUNT-1:0][63:0] mtimecmp_q, mtimecmp_d;

    logic [31:0] rd_adr;
    logic [31:0] rd_word;
    logic [31:0] wr_adr;
    logic        commit;
    logic        wr_mtime_lo;
    logic        wr_mtime_hi;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        rdata_d = '0;
        unique case (state_q)
            BUS_IDLE: begin
                if (wb.CYC && wb.STB) begin
                    state_d = BUS_ACK;
                    we_d    = wb.WE;
                    adr_d   = wb.ADR;
                    wdat_d  = wb.DAT_MOSI;
                    if (!wb.WE) begin
                        rdata_d = rd_word;
                    end
                end
            end
            BUS_ACK: begin
                state_d = BUS_IDLE;
            end
            default: begin
                state_d = BUS_IDLE;
            end
        endcase
    end

    // Read data is captured from the live request so it is ready in the ACK cycle.
    always_comb begin
        rd_adr  = 32'(wb.ADR);
        rd_word = '0;
        for (int unsigned h = 0; h < HART_COUNT; h++) begin
            if (rd_adr == MSIP_BASE + h) begin
                rd_word = {31'd0, msip_q[h]};
            end
            if (rd_adr == mtimecmp_addr(h, 1'b0)) begin
                rd_word = mtimecmp_q[h][31:0];
            end
            if (rd_adr == mtimecmp_addr(h, 1'b1)) begin
                rd_word = mtimecmp_q[h][63:32];
            end
        end
        if (rd_adr == MTIME_LO) begin
            rd_word = mtime[31:0];
        end
        if (rd_adr == MTIME_HI) begin
            rd_word = mtime[63:32];
        end
    end

    assign commit      = (state_q == BUS_ACK) && we_q;
    assign wr_adr      = 32'(adr_q);
    assign wr_mtime_lo = commit && (wr_adr == MTIME_LO);
    assign wr_mtime_hi = commit && (wr_adr == MTIME_HI);

    always_comb begin
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        mtip_d     = '0;
        for (int unsigned h = 0; h < HART_COUNT; h++) begin
            if (commit && (wr_adr == MSIP_BASE + h)) begin
                msip_d[h] = wdat_q[0];
            end
            if (commit && (wr_adr == mtimecmp_addr(h, 1'b0))) begin
                mtimecmp_d[h][31:0] = wdat_q;
            end
            if (commit && (wr_adr == mtimecmp_addr(h, 1'b1))) begin
                mtimecmp_d[h][63:32] = wdat_q;
            end
            mtip_d[h] = (mtime >= mtimecmp_q[h]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BUS_IDLE;
            we_q       <= 1'b0;
            adr_q      <= '0;
            wdat_q     <= '0;
            rdata_q    <= '0;
            msip_q     <= '0;
            mtip_q     <= '0;
            mtimecmp_q <= {HART_COUNT{MTIMECMP_RST}};
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            wdat_q     <= wdat_d;
            rdata_q    <= rdata_d;
            msip_q     <= msip_d;
            mtip_q     <= mtip_d;
            mtimecmp_q <= mtimecmp_d;
        end
    end

    nax_clint_timer #(
        .TICK_DIV_WIDTH(TICK_DIV_WIDTH)
    ) u_timer (
        .clk_i      (clk),
        .rst_i      (reset),
        .tick_div_i (tick_div),
        .stop_time_i(stop_time),
        .wr_lo_i    (wr_mtime_lo),
        .wr_hi_i    (wr_mtime_hi),
        .wdata_i    (wdat_q),
        .mtime_o    (mtime)
    );

    assign wb.ACK             = (state_q == BUS_ACK);
    assign wb.DAT_MISO        = rdata_q;
    assign software_interrupt = msip_q;
    assign timer_interrupt    = mtip_q;

endmodule

// File: tb/tb_nax_clint_wb.sv
// Directed self-checking bench for nax_clint_wb with four harts.
module tb_nax_clint_wb;

    logic        clk;
    logic        reset;
    logic [7:0]  tick_div;
    logic        stop_time;
    logic [63:0] mtime;
    logic [3:0]  timer_interrupt;
    logic [3:0]  software_interrupt;

    int unsigned compared;
    int unsigned mismatched;

    nax_clint_wb_if #(.ADR_WIDTH(14)) bus ();

    nax_clint_wb #(
        .HART_COUNT    (4),
        .ADR_WIDTH     (14),
        .TICK_DIV_WIDTH(8)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .wb                (bus),
        .tick_div          (tick_div),
        .stop_time         (stop_time),
        .mtime             (mtime),
        .timer_interrupt   (timer_interrupt),
        .software_interrupt(software_interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic bus_idle();
        bus.CYC      = 1'b0;
        bus.STB      = 1'b0;
        bus.WE       = 1'b0;
        bus.ADR      = '0;
        bus.DAT_MOSI = '0;
    endtask

    task automatic do_reset(input logic [7:0] tdiv);
        reset     = 1'b1;
        tick_div  = tdiv;
        stop_time = 1'b0;
        bus_idle();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One transfer; returns one sample after the ACK cycle begins, before the commit edge.
    task automatic wb_xfer(input logic we, input logic [13:0] adr, input logic [31:0] wdat,
                           output logic [31:0] rdat);
        int unsigned n;
        @(posedge clk);
        #1;
        bus.CYC      = 1'b1;
        bus.STB      = 1'b1;
        bus.WE       = we;
        bus.ADR      = adr;
        bus.DAT_MOSI = wdat;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.ACK && n < 8);
        if (!bus.ACK) begin
            compared++;
            mismatched++;
            $display("FAIL ack_timeout: adr %h got no ACK, required ACK within 8 cycles", adr);
        end
        rdat = bus.DAT_MISO;
        bus_idle();
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        tick_div  = 8'd0;
        stop_time = 1'b0;
        bus_idle();
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (mtime !== 64'd0) begin
            mismatched++;
            $display("FAIL reset_mtime: got %h required %h", mtime, 64'd0);
        end
        compared++;
        if (bus.ACK !== 1'b0 || bus.DAT_MISO !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_bus: got ack=%b dat=%h required ack=0 dat=0", bus.ACK, bus.DAT_MISO);
        end
        compared++;
        if (timer_interrupt !== 4'b0000 || software_interrupt !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_irq: got mtip=%b msip=%b required 0000/0000",
                     timer_interrupt, software_interrupt);
        end
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] r0, r1;
        do_reset(8'd0);
        wb_xfer(1'b0, 14'h2FFE, 32'd0, r0);
        wb_xfer(1'b0, 14'h2FFE, 32'd0, r1);
        compared++;
        if (r0 !== 32'd1) begin
            mismatched++;
            $display("FAIL b2b_first_read: got %h required %h", r0, 32'd1);
        end
        compared++;
        if (r1 !== 32'd3) begin
            mismatched++;
            $display("FAIL b2b_second_read: got %h required %h", r1, 32'd3);
        end
        @(posedge clk);
        #1;
        compared++;
        if (bus.ACK !== 1'b0 || bus.DAT_MISO !== 32'd0) begin
            mismatched++;
            $display("FAIL b2b_after_ack: got ack=%b dat=%h required ack=0 dat=0", bus.ACK, bus.DAT_MISO);
        end
        wb_xfer(1'b0, 14'h1000, 32'd0, r0);
        compared++;
        if (r0 !== 32'hFFFF_FFFF) begin
            mismatched++;
            $display("FAIL reset_mtimecmp0: got %h required %h", r0, 32'hFFFF_FFFF);
        end
        wb_xfer(1'b0, 14'h1007, 32'd0, r0);
        compared++;
        if (r0 !== 32'hFFFF_FFFF) begin
            mismatched++;
            $display("FAIL reset_mtimecmp3_hi: got %h required %h", r0, 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_prescaler();
        do_reset(8'd3);
        repeat (40) @(posedge clk);
        #1;
        compared++;
        if (mtime !== 64'd10) begin
            mismatched++;
            $display("FAIL prescale_40cyc: got %h required %h", mtime, 64'd10);
        end
        stop_time = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        compared++;
        if (mtime !== 64'd10) begin
            mismatched++;
            $display("FAIL stop_time_hold: got %h required %h", mtime, 64'd10);
        end
        stop_time = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (mtime !== 64'd10) begin
            mismatched++;
            $display("FAIL prescale_resume_3: got %h required %h", mtime, 64'd10);
        end
        @(posedge clk);
        #1;
        compared++;
        if (mtime !== 64'd11) begin
            mismatched++;
            $display("FAIL prescale_resume_4: got %h required %h", mtime, 64'd11);
        end
    endtask

    task automatic test_msip();
        logic [31:0] r;
        do_reset(8'd0);
        @(posedge clk);
        #1;
        bus.CYC      = 1'b1;
        bus.STB      = 1'b1;
        bus.WE       = 1'b1;
        bus.ADR      = 14'h0002;
        bus.DAT_MOSI = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        compared++;
        if (bus.ACK !== 1'b1 || software_interrupt !== 4'b0000) begin
            mismatched++;
            $display("FAIL msip_ack_cycle: got ack=%b msip=%b required ack=1 msip=0000",
                     bus.ACK, software_interrupt);
        end
        bus_idle();
        @(posedge clk);
        #1;
        compared++;
        if (bus.ACK !== 1'b0 || software_interrupt !== 4'b0100) begin
            mismatched++;
            $display("FAIL msip_visible: got ack=%b msip=%b required ack=0 msip=0100",
                     bus.ACK, software_interrupt);
        end
        wb_xfer(1'b0, 14'h0002, 32'd0, r);
        compared++;
        if (r !== 32'h0000_0001) begin
            mismatched++;
            $display("FAIL msip2_read: got %h required %h", r, 32'h0000_0001);
        end
        wb_xfer(1'b0, 14'h0001, 32'd0, r);
        compared++;
        if (r !== 32'h0000_0000) begin
            mismatched++;
            $display("FAIL msip1_read: got %h required %h", r, 32'h0000_0000);
        end
    endtask

    task automatic test_timer_irq();
        logic [31:0] r;
        int unsigned n;
        do_reset(8'd0);
        wb_xfer(1'b1, 14'h1002, 32'h0000_0100, r);
        wb_xfer(1'b1, 14'h1003, 32'h0000_0000, r);
        wb_xfer(1'b1, 14'h2FFE, 32'h0000_00F0, r);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (mtime !== 64'h100 && n < 300);
        compared++;
        if (mtime !== 64'h100 || timer_interrupt !== 4'b0000) begin
            mismatched++;
            $display("FAIL mtip_at_cmp: got mtime=%h mtip=%b required mtime=100 mtip=0000",
                     mtime, timer_interrupt);
        end
        @(posedge clk);
        #1;
        compared++;
        if (mtime !== 64'h101 || timer_interrupt !== 4'b0010) begin
            mismatched++;
            $display("FAIL mtip_rise: got mtime=%h mtip=%b required mtime=101 mtip=0010",
                     mtime, timer_interrupt);
        end
        wb_xfer(1'b1, 14'h1003, 32'h0000_0001, r);
        @(posedge clk);
        #1;
        compared++;
        if (timer_interrupt !== 4'b0010) begin
            mismatched++;
            $display("FAIL mtip_commit_cycle: got %b required %b", timer_interrupt, 4'b0010);
        end
        @(posedge clk);
        #1;
        compared++;
        if (timer_interrupt !== 4'b0000) begin
            mismatched++;
            $display("FAIL mtip_drop: got %b required %b", timer_interrupt, 4'b0000);
        end
    endtask

    task automatic test_wrap_and_collision();
        logic [31:0] r;
        stop_time = 1'b1;
        wb_xfer(1'b1, 14'h2FFF, 32'hFFFF_FFFF, r);
        wb_xfer(1'b1, 14'h2FFE, 32'hFFFF_FFFF, r);
        @(posedge clk);
        #1;
        compared++;
        if (mtime !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            mismatched++;
            $display("FAIL mtime_all_ones: got %h required %h", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        end
        stop_time = 1'b0;
        @(posedge clk);
        #1;
        stop_time = 1'b1;
        compared++;
        if (mtime !== 64'd0) begin
            mismatched++;
            $display("FAIL mtime_wrap: got %h required %h", mtime, 64'd0);
        end
        wb_xfer(1'b0, 14'h2FFF, 32'd0, r);
        compared++;
        if (r !== 32'd0) begin
            mismatched++;
            $display("FAIL mtime_wrap_read_hi: got %h required %h", r, 32'd0);
        end

        wb_xfer(1'b1, 14'h2FFF, 32'h0000_0005, r);
        wb_xfer(1'b1, 14'h2FFE, 32'hFFFF_FFFE, r);
        @(posedge clk);
        #1;
        bus.CYC      = 1'b1;
        bus.STB      = 1'b1;
        bus.WE       = 1'b1;
        bus.ADR      = 14'h2FFE;
        bus.DAT_MOSI = 32'h0000_1234;
        stop_time    = 1'b0;
        @(posedge clk);
        #1;
        bus_idle();
        compared++;
        if (mtime !== 64'h0000_0005_FFFF_FFFF) begin
            mismatched++;
            $display("FAIL collide_pre: got %h required %h", mtime, 64'h0000_0005_FFFF_FFFF);
        end
        @(posedge clk);
        #1;
        compared++;
        if (mtime !== 64'h0000_0005_0000_1234) begin
            mismatched++;
            $display("FAIL collide_write_wins: got %h required %h", mtime, 64'h0000_0005_0000_1234);
        end
        @(posedge clk);
        #1;
        stop_time = 1'b1;
        compared++;
        if (mtime !== 64'h0000_0005_0000_1235) begin
            mismatched++;
            $display("FAIL collide_next_tick: got %h required %h", mtime, 64'h0000_0005_0000_1235);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] r;
        do_reset(8'd0);
        stop_time = 1'b1;
        wb_xfer(1'b0, 14'h0800, 32'd0, r);
        compared++;
        if (r !== 32'd0) begin
            mismatched++;
            $display("FAIL unmapped_read_0800: got %h required %h", r, 32'd0);
        end
        wb_xfer(1'b1, 14'h100A, 32'h0000_0000, r);
        wb_xfer(1'b1, 14'h0005, 32'h0000_0001, r);
        wb_xfer(1'b1, 14'h0004, 32'h0000_0001, r);
        wb_xfer(1'b1, 14'h2FFD, 32'h0000_ABCD, r);
        wb_xfer(1'b0, 14'h1008, 32'd0, r);
        compared++;
        if (r !== 32'd0) begin
            mismatched++;
            $display("FAIL unmapped_read_1008: got %h required %h", r, 32'd0);
        end
        wb_xfer(1'b0, 14'h0005, 32'd0, r);
        compared++;
        if (r !== 32'd0) begin
            mismatched++;
            $display("FAIL unmapped_read_msip5: got %h required %h", r, 32'd0);
        end
        compared++;
        if (software_interrupt !== 4'b0000 || mtime !== 64'd0) begin
            mismatched++;
            $display("FAIL unmapped_no_change: got msip=%b mtime=%h required msip=0000 mtime=0",
                     software_interrupt, mtime);
        end
        stop_time = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] r;
        do_reset(8'd0);
        @(posedge clk);
        #1;
        bus.CYC      = 1'b1;
        bus.STB      = 1'b1;
        bus.WE       = 1'b1;
        bus.ADR      = 14'h0000;
        bus.DAT_MOSI = 32'h0000_0001;
        @(posedge clk);
        #1;
        compared++;
        if (bus.ACK !== 1'b1) begin
            mismatched++;
            $display("FAIL rstmid_ack: got %b required %b", bus.ACK, 1'b1);
        end
        reset = 1'b1;
        bus_idle();
        @(posedge clk);
        #1;
        compared++;
        if (bus.ACK !== 1'b0 || software_interrupt !== 4'b0000) begin
            mismatched++;
            $display("FAIL rstmid_dropped: got ack=%b msip=%b required ack=0 msip=0000",
                     bus.ACK, software_interrupt);
        end
        reset = 1'b0;
        wb_xfer(1'b0, 14'h0000, 32'd0, r);
        compared++;
        if (r !== 32'd0 || software_interrupt !== 4'b0000) begin
            mismatched++;
            $display("FAIL rstmid_msip0: got read=%h msip=%b required read=0 msip=0000",
                     r, software_interrupt);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_back_to_back();
        test_prescaler();
        test_msip();
        test_timer_irq();
        test_wrap_and_collision();
        test_unmapped();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
